// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver. Colours are double-buffered and applied at frame wrap.
// Optional gamma mapping of loaded duties: define RGB_PWM_GAMMA_EN.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb,
  input  logic        rgb_valid,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        frame_done,
  output logic        active
);

  localparam int unsigned NUM_CH = 3;
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [15:0]                   presc_q, presc_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [NUM_CH-1:0][7:0]        duty_q, duty_d;
  logic [23:0]                   pend_q, pend_d;
  logic                          pflag_q, pflag_d;
  logic                          fd_q, fd_d;
  logic [NUM_CH-1:0]             led_q, led_d;
  logic                          tick, boundary;

  // Channel order in duty_q follows rgb: [2]=R, [1]=G, [0]=B.
  function automatic logic [NUM_CH-1:0][7:0] map_rgb(input logic [23:0] c);
    logic [NUM_CH-1:0][7:0] m;
`ifdef RGB_PWM_GAMMA_EN
    logic [15:0] p;
    for (int i = 0; i < NUM_CH; i++) begin
      p    = 16'(c[8*i +: 8]) * 16'(c[8*i +: 8]);
      m[i] = p[15:8];
    end
`else
    m = c;
`endif
    return m;
  endfunction

  assign tick     = (state_q == RUN) && enable && (presc_q == PS_LAST);
  assign boundary = tick && (cnt_q == 8'hFF);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d   = '0;
        if (rgb_valid) begin
          duty_d  = map_rgb(rgb);
          state_d = RUN;
        end
      end
      RUN: begin
        if (enable) begin
          if (tick) begin
            presc_d = '0;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        if (boundary) begin
          fd_d = 1'b1;
          // A colour arriving exactly on the wrap skips the pending stage.
          if (rgb_valid) begin
            duty_d  = map_rgb(rgb);
            pflag_d = 1'b0;
          end else if (pflag_q) begin
            duty_d  = map_rgb(pend_q);
            pflag_d = 1'b0;
          end
        end else if (rgb_valid) begin
          pend_d  = rgb;
          pflag_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
    assign led_d[g] = (state_q == RUN) && enable && (cnt_q < duty_q[g]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      fd_q    <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      fd_q    <= fd_d;
      led_q   <= led_d;
    end
  end

  assign led_r      = led_q[2];
  assign led_g      = led_q[1];
  assign led_b      = led_q[0];
  assign frame_done = fd_q;
  assign active     = (state_q == RUN);

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at PRESCALE=1; frames counted as 256 samples after a wrap.
module tb_rgb_pwm_driver;
  logic        clk = 1'b0;
  logic        rst_n, enable, rgb_valid;
  logic [23:0] rgb;
  logic        led_r, led_g, led_b, frame_done, active;
  int          checks = 0;
  int          errors = 0;

  rgb_pwm_driver #(.PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rgb(rgb), .rgb_valid(rgb_valid),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .frame_done(frame_done), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame of 256 samples; optional single-cycle colour injections at sample ia / ib.
  task automatic frame(input string tag, input int ia, input logic [23:0] ra,
                       input int ib, input logic [23:0] rb,
                       input int er, input int eg, input int eb);
    int nr = 0, ng = 0, nb = 0, nf = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      nr += int'(led_r); ng += int'(led_g); nb += int'(led_b); nf += int'(frame_done);
      rgb_valid = 1'b0;
      if (i == ia) begin rgb = ra; rgb_valid = 1'b1; end
      if (i == ib) begin rgb = rb; rgb_valid = 1'b1; end
    end
    chk({tag, "_r"}, nr, er);
    chk({tag, "_g"}, ng, eg);
    chk({tag, "_b"}, nb, eb);
    chk({tag, "_fd"}, nf, 1);
  endtask

  initial begin
    int acc, k, nr, ng, nb;
    rst_n = 1'b0; enable = 1'b0; rgb = 24'hFFFFFF; rgb_valid = 1'b0;
    // Reset with rgb_valid toggling
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rgb_valid = ~rgb_valid;
    end
    chk("rst_led_r", led_r, 0);
    chk("rst_led_g", led_g, 0);
    chk("rst_led_b", led_b, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_active", active, 0);
    rst_n = 1'b1; rgb_valid = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_active", active, 0);
    chk("idle_leds", {led_r, led_g, led_b}, 0);

    // Basic PWM start from IDLE
    rgb = 24'h80_40_FF; rgb_valid = 1'b1;
    @(negedge clk);
    chk("start_active", active, 1);
    rgb_valid = 1'b0;
    frame("f1", -1, 0, -1, 0, 128, 64, 255);
    frame("f2_mid", 99, 24'h000000, -1, 0, 128, 64, 255);
    frame("f3_zero", 10, 24'h10_10_10, 50, 24'h20_20_20, 0, 0, 0);
    frame("f4_last", 254, 24'hC0_01_00, -1, 0, 32, 32, 32);
    frame("f5_byp", -1, 0, -1, 0, 192, 1, 0);

    // Freeze at cnt=60 for 50 cycles with a capture inside
    nr = 0; ng = 0; nb = 0; acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      nr += int'(led_r); ng += int'(led_g); nb += int'(led_b);
    end
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc += int'(led_r) + int'(led_g) + int'(led_b) + int'(frame_done);
      rgb_valid = (i == 25);
      rgb = 24'h00_FF_00;
    end
    enable = 1'b1; rgb_valid = 1'b0;
    chk("frz_quiet", acc, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      nr += int'(led_r); ng += int'(led_g); nb += int'(led_b);
    end while (!frame_done && k < 400);
    chk("frz_fd_delay", k, 196);
    chk("frz_r", nr, 192);
    chk("frz_g", ng, 1);
    chk("frz_b", nb, 0);
    frame("f7_new", -1, 0, -1, 0, 0, 255, 0);

    // Reset at cnt=130 with a pending colour outstanding
    rgb = 24'h11_22_33; rgb_valid = 1'b1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      rgb_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_leds", {led_r, led_g, led_b}, 0);
    chk("mrst_fd", frame_done, 0);
    chk("mrst_active", active, 0);
    rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc += int'(led_r) + int'(led_g) + int'(led_b) + int'(frame_done) + int'(active);
    end
    chk("mrst_idle", acc, 0);

    // Restart; duties depend on gamma build
    rgb = 24'hFF_80_10; rgb_valid = 1'b1;
    @(negedge clk);
    chk("re_active", active, 1);
    rgb_valid = 1'b0;
`ifdef RGB_PWM_GAMMA_EN
    frame("gam", -1, 0, -1, 0, 254, 64, 1);
`else
    frame("lin", -1, 0, -1, 0, 255, 128, 16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
